// File: rtl/i2c_master_read_byte.sv
// Purpose: reads one DATA_WIDTH-bit byte MSB first through a bit-read sub-unit,
//          then drives the ACK/NACK slot through a bit-write sub-unit.
// Ports:   clock/reset_n; go/ack_in/finish/data toward the transaction controller;
//          bit_read_* and bit_write_* handshakes; scl muxed toward the pad logic.
`timescale 1ns/1ps
module i2c_master_read_byte #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic                  ack_in,
    output logic                  finish,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  bit_read_go,
    input  logic                  bit_read_finish,
    input  logic                  bit_read_data,
    input  logic                  bit_read_scl,
    output logic                  bit_write_go,
    output logic                  bit_write_data,
    input  logic                  bit_write_finish,
    input  logic                  bit_write_scl,
    output logic                  scl
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_GAP,
        ACK,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  ack_bit;
    logic                  scl_hold;

    assign bit_write_data = ack_bit;

    // Next state and outputs. Sub-unit go outputs are gated by go so an abort
    // removes the request in the same cycle go falls.
    always_comb begin
        state_nxt    = state;
        bit_read_go  = 1'b0;
        bit_write_go = 1'b0;
        finish       = 1'b0;
        scl          = scl_hold;
        case (state)
            IDLE: begin
                // finish is never high in IDLE, so go alone starts a byte
                if (go) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                bit_read_go = go;
                scl         = bit_read_scl;
                if (!go) begin
                    state_nxt = IDLE;
                end else if (bit_read_finish) begin
                    state_nxt = (bit_cnt == LAST_BIT) ? ACK : READ_GAP;
                end
            end
            READ_GAP: begin
                // one cycle with bit_read_go low so the sub-unit rearms
                scl = 1'b0;
                state_nxt = go ? READ : IDLE;
            end
            ACK: begin
                bit_write_go = go;
                scl          = bit_write_scl;
                if (!go) begin
                    state_nxt = IDLE;
                end else if (bit_write_finish) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                finish = 1'b1;
                scl    = 1'b0;
                if (!go) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            data     <= '0;
            ack_bit  <= 1'b1;
            scl_hold <= 1'b1;
        end else begin
            state <= state_nxt;
            // remember the last driven SCL so IDLE keeps the line steady
            if (state != IDLE) begin
                scl_hold <= scl;
            end
            case (state)
                IDLE: begin
                    if (go) begin
                        bit_cnt <= '0;
                        shift   <= '0;
                        ack_bit <= ack_in;
                    end
                end
                READ: begin
                    if (go && bit_read_finish) begin
                        shift <= {shift[DATA_WIDTH-2:0], bit_read_data};
                        if (bit_cnt == LAST_BIT) begin
                            // publish the byte including the bit arriving now;
                            // the counter stays put and is cleared on the next start
                            data <= {shift[DATA_WIDTH-2:0], bit_read_data};
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_master_read_byte.md
I2C_MASTER_READ_BYTE -- requirements
Module: i2c_master_read_byte

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per byte read before the ACK slot.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port go, input, 1, level request from the transaction controller; held high for the whole byte.
REQ-005 SHALL have port ack_in, input, 1, ACK-slot value (0 = ACK, 1 = NACK), sampled at start.
REQ-006 SHALL have port finish, output, 1, byte and ACK slot complete.
REQ-007 SHALL have port data, output, DATA_WIDTH, assembled byte, MSB first.
REQ-008 SHALL have ports bit_read_go (output, 1), bit_read_finish (input, 1), bit_read_data (input, 1), bit_read_scl (input, 1): handshake to the bit-read unit.
REQ-009 SHALL have ports bit_write_go (output, 1), bit_write_data (output, 1), bit_write_finish (input, 1), bit_write_scl (input, 1): handshake to the bit-write unit.
REQ-010 SHALL have port scl, output, 1, muxed SCL toward the pad logic.

Function
REQ-011 SHALL implement states IDLE, READ, READ_GAP, ACK, DONE in a registered state machine.
REQ-012 IDLE -> READ SHALL occur when go=1 and finish=0; the same edge SHALL clear bit counter and shift register and latch ack_in into ack_bit.
REQ-013 READ SHALL drive bit_read_go=1; bit_read_go SHALL be 0 in every other state.
REQ-014 In READ with bit_read_finish=1: shift register <= {shift[DATA_WIDTH-2:0], bit_read_data}; counter increments.
REQ-015 READ -> READ_GAP on bit_read_finish=1 when counter < DATA_WIDTH-1; READ_GAP lasts exactly 1 cycle, then READ (gap guarantees the sub-unit sees go low).
REQ-016 READ -> ACK on bit_read_finish=1 when counter = DATA_WIDTH-1; same edge SHALL load data with the completed byte, including the final bit.
REQ-017 ACK SHALL drive bit_write_go=1 and bit_write_data=ack_bit; bit_write_go=0 elsewhere; bit_write_data SHALL hold ack_bit outside ACK.
REQ-018 ACK -> DONE on bit_write_finish=1.
REQ-019 DONE SHALL assert finish=1; finish=0 in all other states; DONE -> IDLE when go=0; finish stays high while go stays high.
REQ-020 Counter width SHALL be clog2(DATA_WIDTH); no wrap occurs in normal operation; counter resets on each start.
REQ-021 scl SHALL equal bit_read_scl in READ and bit_write_scl in ACK; it SHALL be 0 in READ_GAP and DONE.
REQ-022 In IDLE, scl SHALL hold its last driven value in a register.
REQ-023 Abort: go=0 in READ, READ_GAP or ACK SHALL return to IDLE on the next edge; sub-unit go outputs SHALL be 0 from that cycle.
REQ-024 On abort, data SHALL keep its previous value and finish SHALL not assert.
REQ-025 Sub-unit finish inputs SHALL be ignored outside their own state; an ignored finish has no effect.
REQ-026 Latency: start to finish = sum of the 8 bit-read durations + 7 gap cycles + ACK duration + 1 cycle.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, finish=0, data=0, bit_read_go=0, bit_write_go=0, bit_write_data=1, scl=1, counter=0, shift register=0, ack_bit=1.
REQ-028 Reset mid-byte SHALL discard partial data; after release, no activity until go=1 with finish=0.

Verification
REQ-029 Read with ACK: go=1, ack_in=0, bit-read model returns 1,0,1,0,0,1,0,1 -> data=0xA5, bit_write_data=0 in ACK, finish=1 until go drops.
REQ-030 Read with NACK: ack_in=1, bits 0xFF -> data=0xFF, bit_write_data=1 during ACK.
REQ-031 Gap check: bit-read model finish after 5 cycles per bit -> bit_read_go low exactly 1 cycle between bits; exactly 8 bit_read_go rising edges.
REQ-032 Abort: go dropped after the 3rd bit -> IDLE next edge, data keeps its prior value (e.g. 0x3C), finish stays 0.
REQ-033 Reset mid-ACK: reset_n=0 during ACK -> all outputs at REQ-027 values asynchronously; a new go then reads a fresh byte correctly.
REQ-034 Back-to-back: go held high through finish -> no restart; go low 1 cycle then high -> second byte 0x5A read correctly.
